// File: rtl/mac_accumulator.sv
// Accumulates groups of N unsigned products into an ACC_W-bit sum with a sticky
// per-group carry flag; results leave on a valid/ready port held under backpressure.
module mac_accumulator #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 10,
    parameter int N     = 4,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_acc;
    logic [ACC_W:0]   sum;
    logic             in_fire;
    logic             out_fire;
    logic             last;

    // While a result is pending, a new product is only taken if the result leaves
    // in the same cycle, which keeps the pipeline bubble-free at group boundaries.
    assign out_valid = (state == HOLD);
    assign in_ready  = (state == ACCUM) || out_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign sum       = {1'b0, acc} + (ACC_W+1)'(in_data);
    assign last      = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (in_fire && last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_next = (in_fire && last) ? HOLD : ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // acc and cnt are always zero in HOLD, so an accepted product is handled the
    // same way in both states.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (in_fire) begin
            if (last) begin
                out_data <= sum[ACC_W-1:0];
                out_ovf  <= ovf_acc | sum[ACC_W];
                acc      <= '0;
                cnt      <= '0;
                ovf_acc  <= 1'b0;
            end else begin
                acc      <= sum[ACC_W-1:0];
                ovf_acc  <= ovf_acc | sum[ACC_W];
                cnt      <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: default, ACC_W=8 and N=1 instances,
// table-driven groups scored through a queue plus hand-written corner sequences.
module tb_mac_accumulator;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [7:0] a_in_data;
    logic [9:0] a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0] b_in_data;
    logic [7:0] b_out_data;
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
    logic [7:0] c_in_data;
    logic [9:0] c_out_data;

    mac_accumulator dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    mac_accumulator #(.IN_W(8), .ACC_W(8), .N(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    mac_accumulator #(.IN_W(8), .ACC_W(10), .N(1), .CNT_W(1)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_ovf(c_out_ovf)
    );

    typedef struct {
        logic [7:0] d[4];
        logic [9:0] sum;
        logic       ovf;
    } vec_t;

    typedef struct {
        logic [9:0] sum;
        logic       ovf;
    } exp_t;

    exp_t       sbq[$];
    vec_t       tbl[7];
    logic [7:0] bseq[8];
    logic [7:0] cseq[3];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input int p0, input int p1, input int p2, input int p3,
                                   input int s, input int o);
        vec_t v;
        v.d[0] = 8'(p0);
        v.d[1] = 8'(p1);
        v.d[2] = 8'(p2);
        v.d[3] = 8'(p3);
        v.sum  = 10'(s);
        v.ovf  = 1'(o);
        return v;
    endfunction

    // Offers one product to dut_a and returns just after the edge that accepts it.
    task automatic applyStimulus(input logic [7:0] d);
        int waitc;
        waitc = 0;
        a_in_valid = 1'b1;
        a_in_data  = d;
        @(negedge clk);
        while (!a_in_ready && waitc < 50) begin
            waitc++;
            @(negedge clk);
        end
        if (!a_in_ready) begin
            total++;
            $display("[TB] FAIL accept_timeout: in_ready=%0d, expected 1", a_in_ready);
            a_in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            a_in_valid = 1'b0;
            a_in_data  = 8'hAA;
        end
    endtask

    task automatic pushExpected(input logic [9:0] s, input logic o);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        sbq.push_back(e);
    endtask

    task automatic applyGroup(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) pushExpected(v.sum, v.ovf);
            applyStimulus(v.d[k]);
        end
        checkOutput("latency_valid", 32'(a_out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every result leaving dut_a is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && !rst && a_out_valid && a_out_ready) begin
            if (sbq.size() == 0) begin
                total++;
                $display("[TB] FAIL sb_unexpected: result %0d with no expectation queued", a_out_data);
            end else begin
                e = sbq.pop_front();
                checkOutput("sb_data", 32'(a_out_data), 32'(e.sum));
                checkOutput("sb_ovf", 32'(a_out_ovf), 32'(e.ovf));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = 8'h00; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = 8'h00; b_out_ready = 1'b0;
        c_in_valid = 1'b0; c_in_data = 8'h00; c_out_ready = 1'b0;

        tbl[0] = mkvec(10, 20, 30, 40, 100, 0);
        tbl[1] = mkvec(1, 2, 3, 4, 10, 0);
        tbl[2] = mkvec(5, 6, 7, 8, 26, 0);
        tbl[3] = mkvec(200, 100, 50, 25, 375, 0);
        tbl[4] = mkvec(0, 0, 0, 0, 0, 0);
        tbl[5] = mkvec(255, 0, 255, 1, 511, 0);
        tbl[6] = mkvec(255, 255, 255, 255, 1020, 0);
        bseq = '{8'd255, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
        cseq = '{8'd5, 8'd6, 8'd7};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("rst_out_ovf", 32'(a_out_ovf), 32'd0);
        checkOutput("rst_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        mon_en = 1'b1;

        // Back-to-back groups with out_ready high: 28 products in 28 cycles.
        a_out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 7; i++) applyGroup(tbl[i]);
        checkOutput("stream_cycles", 32'(cyc - start), 32'd28);
        idle(1);
        checkOutput("valid_one_cycle", 32'(a_out_valid), 32'd0);

        // Backpressure, then release together with the first product of the next group.
        a_out_ready = 1'b0;
        applyGroup(mkvec(255, 255, 255, 255, 1020, 0));
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(a_out_valid), 32'd1);
            checkOutput("hold_data", 32'(a_out_data), 32'd1020);
            checkOutput("hold_ovf", 32'(a_out_ovf), 32'd0);
            checkOutput("hold_in_ready", 32'(a_in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;
        applyGroup(tbl[1]);
        idle(1);
        checkOutput("release_in_ready", 32'(a_in_ready), 32'd1);
        checkOutput("release_valid", 32'(a_out_valid), 32'd0);

        // Reset in the middle of a group discards the partial sum.
        applyStimulus(8'd10);
        applyStimulus(8'd20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", 32'(a_out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(a_out_data), 32'd0);
        checkOutput("midrst_in_ready", 32'(a_in_ready), 32'd1);
        applyGroup(tbl[1]);

        // Idle cycles inside a group, with garbage on in_data while in_valid is low.
        applyStimulus(8'd3);
        idle(2);
        applyStimulus(8'd0);
        applyStimulus(8'd9);
        idle(1);
        pushExpected(10'd112, 1'b0);
        applyStimulus(8'd100);
        checkOutput("gap_latency_valid", 32'(a_out_valid), 32'd1);
        idle(2);
        checkOutput("sb_empty", 32'(sbq.size()), 32'd0);

        // ACC_W=8: carry sets the sticky flag, which clears for the next group.
        b_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = bseq[i];
            @(posedge clk);
            #1;
            checkOutput("ovf_in_ready", 32'(b_in_ready), 32'd1);
            if (i == 3) begin
                checkOutput("ovf_valid", 32'(b_out_valid), 32'd1);
                checkOutput("ovf_data", 32'(b_out_data), 32'd0);
                checkOutput("ovf_flag", 32'(b_out_ovf), 32'd1);
            end
            if (i == 4) checkOutput("ovf_valid_drop", 32'(b_out_valid), 32'd0);
            if (i == 7) begin
                checkOutput("ovf2_valid", 32'(b_out_valid), 32'd1);
                checkOutput("ovf2_data", 32'(b_out_data), 32'd4);
                checkOutput("ovf2_flag", 32'(b_out_ovf), 32'd0);
            end
        end
        b_in_valid = 1'b0;

        // N=1: one result per cycle, then backpressure with in_ready following out_ready.
        c_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_in_valid = 1'b1;
            c_in_data  = cseq[i];
            @(posedge clk);
            #1;
            checkOutput("n1_valid", 32'(c_out_valid), 32'd1);
            checkOutput("n1_data", 32'(c_out_data), 32'(cseq[i]));
            checkOutput("n1_ovf", 32'(c_out_ovf), 32'd0);
        end
        c_in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("n1_drain_valid", 32'(c_out_valid), 32'd0);
        c_out_ready = 1'b0;
        c_in_valid  = 1'b1;
        c_in_data   = 8'd9;
        @(posedge clk);
        #1;
        checkOutput("n1_bp_data", 32'(c_out_data), 32'd9);
        checkOutput("n1_bp_in_ready", 32'(c_in_ready), 32'd0);
        c_in_data = 8'd11;
        @(posedge clk);
        #1;
        checkOutput("n1_bp_hold", 32'(c_out_data), 32'd9);
        c_out_ready = 1'b1;
        #1;
        checkOutput("n1_passthru", 32'(c_in_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("n1_next_valid", 32'(c_out_valid), 32'd1);
        checkOutput("n1_next_data", 32'(c_out_data), 32'd11);
        c_in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("n1_final_valid", 32'(c_out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream consumer of the team's 4x4 combinational multiplier: accepts its 8-bit products over a valid/ready handshake.
- Sums groups of exactly N consecutive products into an ACC_W-bit total.
- Presents each completed sum on a valid/ready output port, held stable under backpressure, with a sticky overflow flag per group.
- Used as the accumulate half of a multiply-accumulate (dot-product) datapath.

Parameters:
- IN_W, 8, product width; matches the multiplier output.
- ACC_W, 10, accumulator/result width; must be >= IN_W.
- N, 4, products per group; must be >= 1.
- CNT_W, 2, group counter width; must satisfy 2^CNT_W >= N.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data holds a product.
- in_ready, output, 1, block can accept a product this cycle.
- in_data, input, IN_W, unsigned product from the multiplier.
- out_valid, output, 1, out_data/out_ovf hold a completed group result.
- out_ready, input, 1, downstream accepts the result this cycle.
- out_data, output, ACC_W, group sum modulo 2^ACC_W.
- out_ovf, output, 1, a carry out of ACC_W occurred during this group.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready at a rising edge.
- Reset (sync, rst=1 at edge):
  - acc=0, cnt=0, ovf_acc=0, state=ACCUM.
  - out_valid=0, out_data=0, out_ovf=0.
  - in_ready is 1 on the first cycle after reset.
  - Reset overrides any concurrent transfer.
  - A partial group is discarded; no output is produced for it.
- States:
  - ACCUM: no result pending; in_ready=1.
  - HOLD: result pending; out_valid=1; in_ready=out_ready (combinational pass-through).
- Accept in ACCUM:
  - sum = acc + zero-extended in_data, computed at ACC_W+1 bits.
  - If cnt != N-1: acc <= sum[ACC_W-1:0]; ovf_acc <= ovf_acc | sum[ACC_W]; cnt++.
  - If cnt == N-1:
    - out_data <= sum[ACC_W-1:0]; out_ovf <= ovf_acc | sum[ACC_W]; out_valid <= 1.
    - acc <= 0; ovf_acc <= 0; cnt <= 0; state -> HOLD.
- Latency: out_valid rises on the cycle after the edge that accepts the Nth product.
- HOLD:
  - out_data/out_ovf stay stable until the output transfer.
  - Output transfer with no input transfer: out_valid <= 0; state -> ACCUM.
  - Output and input transfer in the same cycle: the input is the first product of the next group and is processed exactly as in ACCUM.
  - Same cycle, N==1: the new result is loaded into out_data/out_ovf; out_valid stays 1; state stays HOLD. Sustains 1 result/cycle.
  - Same cycle, N>1: out_valid <= 0; state -> ACCUM; acc = in_data; cnt = 1.
- Throughput: one product per cycle with no bubbles at group boundaries when out_ready=1.
- Arithmetic:
  - Unsigned only; the sum wraps modulo 2^ACC_W.
  - ovf is sticky within a group and cleared at group start.
- in_data is ignored when no input transfer occurs. The block must not stall when in_valid=0 (idle cycles are allowed mid-group).
- No combinational path from in_valid/in_data to any output. The only combinational input->output path is out_ready->in_ready in HOLD.

Test Plan:
1. Defaults: products 10,20,30,40 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, one cycle after the 4th accept; out_data=100, out_ovf=0.
2. Backpressure: products 255 x4 with out_ready=0 for 5 cycles after completion -> out_data=1020 held stable, in_ready=0 throughout; raise out_ready -> transfer, then in_ready=1.
3. Overflow (ACC_W=8 override): products 255,1,0,0 -> out_data=0, out_ovf=1; next group 1,1,1,1 -> out_data=4, out_ovf=0 (sticky flag cleared).
4. Continuous streaming: 8 products 1..8 with in_valid=1, out_ready=1 every cycle -> results 10 then 26; in_ready never deasserts; no product dropped or duplicated.
5. N=1 override with out_ready=1 and products 5,6,7 every cycle -> out_valid stays high; out_data 5,6,7 on consecutive cycles.
6. Reset mid-group: accept 10,20, then assert rst for 1 cycle; then accept 1,2,3,4 -> single result out_data=10; no output emitted for the discarded partial group.
